// File: rtl/az_f1f2_seq_if.sv
// Handshake, coefficient-RAM read port and f1/f2 array write ports of az_f1f2_seq.
// master: the sequencer side; slave: the surrounding LSP datapath.
interface az_f1f2_seq_if #(
    parameter int unsigned ADDR_W = 7
) ();
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_dout;
    logic [3:0]        sel;
    logic [15:0]       f1_q;
    logic              f1_ld;
    logic [15:0]       f2_q;
    logic              f2_ld;
    logic              ovf;

    modport master (
        input  start, mem_dout,
        output busy, done, mem_rd, mem_addr, sel, f1_q, f1_ld, f2_q, f2_ld, ovf
    );

    modport slave (
        output start, mem_dout,
        input  busy, done, mem_rd, mem_addr, sel, f1_q, f1_ld, f2_q, f2_ld, ovf
    );
endinterface

// File: rtl/az_f1f2_seq.sv
// A(z) -> f1/f2 sum/difference polynomial sequencer feeding the Chebyshev root search.
// Optional feature macro AZ_F1F2_SAT_EN: saturate f1/f2 and raise sticky ovf instead of wrapping.
module az_f1f2_seq #(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned BASE_ADDR = 0
) (
    input logic           clk,
    input logic           reset,
    az_f1f2_seq_if.master bus
);
    typedef enum logic [2:0] {StIdle, StInit, StRdLo, StRdHi, StCalc, StDone} state_e;

    state_e              state_q;
    logic [2:0]          i_q;
    logic signed [15:0]  p1_q, p2_q;
    logic signed [15:0]  a_lo_q;
    logic                ovf_q;
    logic                busy_q, done_q, mem_rd_q, ld_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [3:0]          sel_q;

    logic signed [17:0]  a_lo_x, a_hi_x, s, d, f1_w, f2_w;
    logic signed [15:0]  f1_r, f2_r;
    logic                clamp;

    // a_hi is taken straight off the RAM data bus during CALC
    always_comb begin
        a_lo_x = {{2{a_lo_q[15]}}, a_lo_q};
        a_hi_x = {{2{bus.mem_dout[15]}}, bus.mem_dout};
        s      = (a_lo_x + a_hi_x) >>> 3;
        d      = (a_lo_x - a_hi_x) >>> 3;
        f1_w   = s - {{2{p1_q[15]}}, p1_q};
        f2_w   = d + {{2{p2_q[15]}}, p2_q};
    end

`ifdef AZ_F1F2_SAT_EN
    always_comb begin
        clamp = 1'b0;
        if (f1_w > 18'sd32767) begin
            f1_r  = 16'sh7fff;
            clamp = 1'b1;
        end else if (f1_w < -18'sd32768) begin
            f1_r  = -16'sh8000;
            clamp = 1'b1;
        end else begin
            f1_r = 16'(f1_w);
        end
        if (f2_w > 18'sd32767) begin
            f2_r  = 16'sh7fff;
            clamp = 1'b1;
        end else if (f2_w < -18'sd32768) begin
            f2_r  = -16'sh8000;
            clamp = 1'b1;
        end else begin
            f2_r = 16'(f2_w);
        end
    end
`else
    always_comb begin
        f1_r  = 16'(f1_w);
        f2_r  = 16'(f2_w);
        clamp = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            i_q        <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
            a_lo_q     <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            ld_q       <= 1'b0;
            mem_addr_q <= '0;
            sel_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StInit;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        ld_q    <= 1'b1;
                        sel_q   <= '0;
                    end
                end
                StInit: begin
                    p1_q       <= 16'sd1024;
                    p2_q       <= 16'sd1024;
                    i_q        <= '0;
                    ld_q       <= 1'b0;
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= ADDR_W'(BASE_ADDR + 32'd1);
                    state_q    <= StRdLo;
                end
                StRdLo: begin
                    mem_addr_q <= ADDR_W'(BASE_ADDR + 32'd10 - 32'(i_q));
                    state_q    <= StRdHi;
                end
                StRdHi: begin
                    a_lo_q     <= signed'(bus.mem_dout);
                    mem_rd_q   <= 1'b0;
                    mem_addr_q <= '0;
                    ld_q       <= 1'b1;
                    sel_q      <= 4'(i_q) + 4'd1;
                    state_q    <= StCalc;
                end
                StCalc: begin
                    p1_q  <= f1_r;
                    p2_q  <= f2_r;
                    i_q   <= i_q + 3'd1;
                    ld_q  <= 1'b0;
                    sel_q <= '0;
                    if (clamp) ovf_q <= 1'b1;
                    if (i_q == 3'd4) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= ADDR_W'(BASE_ADDR + 32'(i_q) + 32'd2);
                        state_q    <= StRdLo;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.sel      = sel_q;
    assign bus.f1_ld    = ld_q;
    assign bus.f2_ld    = ld_q;
    // Write data exists only in INIT (constant 1.0) and CALC (fresh result)
    assign bus.f1_q     = (state_q == StCalc) ? f1_r :
                          (state_q == StInit) ? 16'd1024 : 16'd0;
    assign bus.f2_q     = (state_q == StCalc) ? f2_r :
                          (state_q == StInit) ? 16'd1024 : 16'd0;
    // A clamp is visible in the same cycle as the write that caused it
    assign bus.ovf      = ovf_q | ((state_q == StCalc) & clamp);
endmodule

// File: tb/tb_az_f1f2_seq.sv
// Bench for az_f1f2_seq: per-cycle comparison against a polynomial model keyed on cycles since start.
// Honours AZ_F1F2_SAT_EN the same way the design does.
module tb_az_f1f2_seq;
    localparam int unsigned AW   = 7;
    localparam int unsigned BASE = 16;
`ifdef AZ_F1F2_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    az_f1f2_seq_if #(.ADDR_W(AW)) bus ();

    az_f1f2_seq #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic signed [15:0] mem [0:127];
    always @(posedge clk) if (bus.mem_rd) bus.mem_dout <= mem[bus.mem_addr];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: expected writes for entries 0..5 and whether each clamped
    int ef1 [6];
    int ef2 [6];
    bit ecl [6];
    bit any_clamp;

    function automatic int reduce16(input int v, output bit c);
        logic signed [15:0] t;
        c = 1'b0;
        if (SAT) begin
            if (v > 32767) begin c = 1'b1; return 32767; end
            if (v < -32768) begin c = 1'b1; return -32768; end
            return v;
        end
        t = v[15:0];
        return int'(t);
    endfunction

    task automatic build_model();
        int p1, p2, lo, hi, s, d;
        bit c1, c2;
        p1 = 1024; p2 = 1024;
        ef1[0] = 1024; ef2[0] = 1024; ecl[0] = 1'b0;
        any_clamp = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            lo = int'(mem[BASE + j]);
            hi = int'(mem[BASE + 11 - j]);
            s = (lo + hi) >>> 3;
            d = (lo - hi) >>> 3;
            ef1[j] = reduce16(s - p1, c1);
            ef2[j] = reduce16(d + p2, c2);
            ecl[j] = c1 | c2;
            any_clamp = any_clamp | c1 | c2;
            p1 = ef1[j];
            p2 = ef2[j];
        end
    endtask

    // Sequence tracker: k = cycles since the accepted start (INIT is k=1, DONE is k=17)
    bit active   = 1'b0;
    int k        = 0;
    bit ovf_hold = 1'b0;
    bit chk_en   = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            active <= 1'b0; k <= 0; ovf_hold <= 1'b0;
        end else if (active) begin
            if (k == 17) begin
                active <= 1'b0; k <= 0; ovf_hold <= any_clamp;
            end else begin
                k <= k + 1;
            end
        end else if (bus.start) begin
            active <= 1'b1; k <= 1; ovf_hold <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit e_ld, e_rd, e_ovf;
            int j, e_addr;
            e_ld  = active && (k == 1 || (k >= 4 && k <= 16 && (k - 1) % 3 == 0));
            j     = (k - 1) / 3;
            e_rd  = active && k >= 2 && k <= 15 && (k % 3 != 1);
            e_addr = !e_rd ? 0 : (k % 3 == 2) ? BASE + (k - 2) / 3 + 1 : BASE + 10 - (k - 3) / 3;
            e_ovf = ovf_hold;
            if (active) begin
                e_ovf = 1'b0;
                for (int m = 1; m <= 5; m++) if (ecl[m] && 3 * m + 1 <= k) e_ovf = 1'b1;
            end
            chk("busy", int'(bus.busy), int'(active && k <= 16));
            chk("done", int'(bus.done), int'(active && k == 17));
            chk("f1_ld", int'(bus.f1_ld), int'(e_ld));
            chk("f2_ld", int'(bus.f2_ld), int'(e_ld));
            chk("sel", int'(bus.sel), e_ld ? j : 0);
            chk("f1_q", int'($signed(bus.f1_q)), e_ld ? ef1[j] : 0);
            chk("f2_q", int'($signed(bus.f2_q)), e_ld ? ef2[j] : 0);
            chk("mem_rd", int'(bus.mem_rd), int'(e_rd));
            chk("mem_addr", int'(bus.mem_addr), e_addr);
            chk("ovf", int'(bus.ovf), int'(e_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (17) tick();
    endtask

    initial begin
        bus.start = 1'b0;
        for (int a = 0; a < 128; a++) mem[a] = 16'sd0;
        build_model();
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // All-zero taps: f1 alternates sign, f2 stays at 1.0
        build_model();
        chk("pin_zero_f1_1", ef1[1], -1024);
        chk("pin_zero_f1_2", ef1[2], 1024);
        chk("pin_zero_f2_5", ef2[5], 1024);
        run_seq();

        // Single tap a[1]; neighbours of the a[1..10] window are poisoned
        mem[BASE] = 16'sd555;
        mem[BASE + 11] = 16'sd777;
        mem[BASE + 1] = 16'sd8192;
        build_model();
        chk("pin_tap_f1_1", ef1[1], 0);
        chk("pin_tap_f2_1", ef2[1], 2048);
        chk("pin_tap_f2_4", ef2[4], 2048);
        run_seq();

        // Full-scale taps drive f2 past the 16-bit range
        for (int a = 1; a <= 5; a++) mem[BASE + a] = 16'sh7fff;
        for (int a = 6; a <= 10; a++) mem[BASE + a] = -16'sh8000;
        build_model();
        chk("pin_sat_f1_1", ef1[1], -1025);
        chk("pin_sat_f2_1", ef2[1], 9215);
        chk("pin_sat_f2_3", ef2[3], 25597);
        chk("pin_sat_f2_4", ef2[4], SAT ? 32767 : -31748);
        chk("pin_sat_f2_5", ef2[5], SAT ? 32767 : -23557);
        chk("pin_sat_clamp", int'(any_clamp), int'(SAT));
        run_seq();
        repeat (3) tick();

        // start held high: one sequence, then a second accepted in the IDLE cycle after DONE
        bus.start = 1'b1;
        repeat (23) tick();
        bus.start = 1'b0;
        repeat (16) tick();

        // Reset in the middle of a sequence, then a clean run
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        run_seq();
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
